// File: rtl/shiftright_pkg.sv
// shiftright_pkg: register map, field layout and shift clamp helper for shiftright_core
package shiftright_pkg;
  localparam logic [19:0] REG_SHIFT = 20'h00;
  localparam logic [19:0] REG_SAT_COUNT = 20'h04;
  localparam logic [19:0] REG_COMPAT = 20'h08;
  localparam int SHIFT_W = 5;
  localparam int ROUND_BIT = 8;
  localparam logic [31:0] COMPAT = 32'h0001_0000;
  localparam logic [SHIFT_W-1:0] SHIFT_MIN = 5'h18;
  localparam logic [SHIFT_W-1:0] SHIFT_MAX = 5'h0f;
  // Left shifts beyond 8 would overflow the 24-bit working width, so -16..-9 become -8
  function automatic logic [SHIFT_W-1:0] clamp_shift(input logic [SHIFT_W-1:0] s);
    return (s[SHIFT_W-1] && s < SHIFT_MIN) ? SHIFT_MIN : s;
  endfunction
endpackage

// File: rtl/shiftright_lane.sv
// shiftright_lane: one signed 16-bit lane, stage 1 shift/round to 24 bits, stage 2 saturate
module shiftright_lane
  import shiftright_pkg::*;
(
  input  logic                      clk,
  input  logic                      en1,
  input  logic                      en2,
  input  logic signed [15:0]        x,
  input  logic        [SHIFT_W-1:0] shift,
  input  logic                      round,
  output logic        [15:0]        y,
  output logic                      sat
);
  logic [3:0] ra, la;
  logic signed [16:0] rnd;
  logic signed [23:0] w_d, w;
  logic hi, lo;
  assign ra = shift[3:0];
  assign la = 4'(-shift);
  assign rnd = {x[15], x} + (17'(round && ra != 4'd0) << (ra - 4'd1));
  assign w_d = shift[SHIFT_W-1] ? 24'(x) <<< la : 24'(rnd >>> ra);
  assign hi = w > 24'sd32767;
  assign lo = w < -24'sd32768;
  assign sat = hi || lo;
  always_ff @(posedge clk) begin
    if (en1) w <= w_d;
    if (en2) y <= hi ? 16'h7fff : lo ? 16'h8000 : w[15:0];
  end
endmodule

// File: rtl/shiftright_core.sv
// shiftright_core: sc16 arithmetic shift with round/saturate, CtrlPort registers, context passthrough
module shiftright_core
  import shiftright_pkg::*;
#(
  parameter int CHDR_W = 64,
  parameter int SAT_CNT_W = 32
) (
  input  logic              ce_clk,
  input  logic              ce_rst,
  input  logic              s_ctrlport_req_wr,
  input  logic              s_ctrlport_req_rd,
  input  logic [19:0]       s_ctrlport_req_addr,
  input  logic [31:0]       s_ctrlport_req_data,
  output logic              s_ctrlport_resp_ack,
  output logic [31:0]       s_ctrlport_resp_data,
  input  logic [31:0]       s_in_payload_tdata,
  input  logic              s_in_payload_tkeep,
  input  logic              s_in_payload_tlast,
  input  logic              s_in_payload_tvalid,
  output logic              s_in_payload_tready,
  output logic [31:0]       m_out_payload_tdata,
  output logic              m_out_payload_tkeep,
  output logic              m_out_payload_tlast,
  output logic              m_out_payload_tvalid,
  input  logic              m_out_payload_tready,
  input  logic [CHDR_W-1:0] s_in_context_tdata,
  input  logic [3:0]        s_in_context_tuser,
  input  logic              s_in_context_tlast,
  input  logic              s_in_context_tvalid,
  output logic              s_in_context_tready,
  output logic [CHDR_W-1:0] m_out_context_tdata,
  output logic [3:0]        m_out_context_tuser,
  output logic              m_out_context_tlast,
  output logic              m_out_context_tvalid,
  input  logic              m_out_context_tready
);
  logic [SHIFT_W-1:0] shift_reg, act_shift, eff_shift;
  logic round_reg, act_round, eff_round, sop;
  logic v1, v2, keep1, keep2, last1, last2, adv1, adv2, in_hs, sat_i, sat_q, inc, clr;
  logic [SAT_CNT_W-1:0] sat_cnt;
  logic [31:0] shift_rd, rd_data;
  assign adv2 = !v2 || m_out_payload_tready;
  assign adv1 = !v1 || adv2;
  assign s_in_payload_tready = adv1;
  assign in_hs = s_in_payload_tvalid && adv1;
  // The first beat of a packet uses the live register; later beats reuse what it latched
  assign eff_shift = sop ? clamp_shift(shift_reg) : act_shift;
  assign eff_round = sop ? round_reg : act_round;
  assign clr = s_ctrlport_req_wr && s_ctrlport_req_addr == REG_SAT_COUNT;
  assign inc = adv2 && v1 && (sat_i || sat_q);
  always_comb begin
    shift_rd = '0;
    shift_rd[SHIFT_W-1:0] = shift_reg;
    shift_rd[ROUND_BIT] = round_reg;
    rd_data = (s_ctrlport_req_addr == REG_SHIFT) ? shift_rd :
              (s_ctrlport_req_addr == REG_SAT_COUNT) ? 32'(sat_cnt) :
              (s_ctrlport_req_addr == REG_COMPAT) ? COMPAT : 32'd0;
  end
  always_ff @(posedge ce_clk) begin
    if (ce_rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      sop <= 1'b1;
      shift_reg <= '0;
      round_reg <= 1'b0;
      act_shift <= '0;
      act_round <= 1'b0;
      sat_cnt <= '0;
      s_ctrlport_resp_ack <= 1'b0;
      s_ctrlport_resp_data <= '0;
    end else begin
      if (adv1) begin
        v1 <= s_in_payload_tvalid;
        keep1 <= s_in_payload_tkeep;
        last1 <= s_in_payload_tlast;
      end
      if (adv2) begin
        v2 <= v1;
        keep2 <= keep1;
        last2 <= last1;
      end
      if (in_hs) begin
        sop <= s_in_payload_tlast;
        act_shift <= eff_shift;
        act_round <= eff_round;
      end
      if (s_ctrlport_req_wr && s_ctrlport_req_addr == REG_SHIFT) begin
        shift_reg <= s_ctrlport_req_data[SHIFT_W-1:0];
        round_reg <= s_ctrlport_req_data[ROUND_BIT];
      end
      if (clr) sat_cnt <= '0;
      else if (inc && !(&sat_cnt)) sat_cnt <= sat_cnt + 1'b1;
      s_ctrlport_resp_ack <= s_ctrlport_req_wr || s_ctrlport_req_rd;
      s_ctrlport_resp_data <= s_ctrlport_req_rd ? rd_data : 32'd0;
    end
  end
  shiftright_lane u_lane_i (
    .clk(ce_clk), .en1(adv1), .en2(adv2), .x(s_in_payload_tdata[31:16]),
    .shift(eff_shift), .round(eff_round), .y(m_out_payload_tdata[31:16]), .sat(sat_i)
  );
  shiftright_lane u_lane_q (
    .clk(ce_clk), .en1(adv1), .en2(adv2), .x(s_in_payload_tdata[15:0]),
    .shift(eff_shift), .round(eff_round), .y(m_out_payload_tdata[15:0]), .sat(sat_q)
  );
  assign m_out_payload_tvalid = v2;
  assign m_out_payload_tkeep = keep2;
  assign m_out_payload_tlast = last2;
  assign m_out_context_tdata = s_in_context_tdata;
  assign m_out_context_tuser = s_in_context_tuser;
  assign m_out_context_tlast = s_in_context_tlast;
  assign m_out_context_tvalid = s_in_context_tvalid;
  assign s_in_context_tready = m_out_context_tready;
endmodule

// File: doc/shiftright_core.md
Name: shiftright_core

Overview:
User-logic datapath of the shiftright RFNoC block. It sits between the block's NoC shell payload/context streams on the ce_clk domain. Each 32-bit sc16 item (I in [31:16], Q in [15:0]) is arithmetically shifted by a programmable amount, with optional rounding and saturation. It also exposes a CtrlPort register file, and context passes through unchanged.

Parameters:
CHDR_W, 64, context stream width (matches NoC shell)
SAT_CNT_W, 32, width of saturation event counter (≤32)

Ports:
ce_clk  in  1  block clock (CtrlPort and AXIS share it)
ce_rst  in  1  synchronous, active-high reset
s_ctrlport_req_wr  in  1  register write strobe
s_ctrlport_req_rd  in  1  register read strobe
s_ctrlport_req_addr  in  20  byte address
s_ctrlport_req_data  in  32  write data
s_ctrlport_resp_ack  out  1  response strobe
s_ctrlport_resp_data  out  32  read data
s_in_payload_tdata/tkeep/tlast/tvalid  in  32/1/1/1  input samples
s_in_payload_tready  out  1
m_out_payload_tdata/tkeep/tlast/tvalid  out  32/1/1/1  output samples
m_out_payload_tready  in  1
s_in_context_tdata/tuser/tlast/tvalid  in  CHDR_W/4/1/1  input context
s_in_context_tready  out  1
m_out_context_tdata/tuser/tlast/tvalid  out  CHDR_W/4/1/1  output context
m_out_context_tready  in  1

Behaviour:
- Clock and reset: one clock, ce_clk. Reset ce_rst is synchronous and active-high. While reset is asserted:
  - all valids and resp_ack are 0, resp_data is 0
  - SHIFT = 0, ROUND_EN = 0, sat counter = 0, sop = 1
- Reset mid-packet: pipeline contents are discarded without output.
- Register map:
  - 0x00 REG_SHIFT, RW. [4:0] is a signed shift amount: positive means right shift 0..15, negative means left shift. Values -16..-9 clamp to -8. [8] is ROUND_EN. Other bits read 0.
  - 0x04 REG_SAT_COUNT, RO. Saturating count of output beats where I or Q saturated; it holds at all-ones. Any write clears it.
  - 0x08 REG_COMPAT, RO. Returns 0x0001_0000.
- CtrlPort timing: ack is asserted exactly one cycle after wr or rd. Unmapped reads return 0 with ack; unmapped writes are acked and ignored.
- Shift latching: active shift/round are latched from REG_SHIFT on the first payload beat of each packet (sop=1 and handshake). sop clears on that beat and sets again on a tlast handshake. A register write mid-packet takes effect on the next packet.
- Per-lane arithmetic (I and Q independent, signed 16-bit):
  - right, ROUND_EN=0: y = x >>> s
  - right, ROUND_EN=1, s>0: y = (x + 2^(s-1)) >>> s, computed in 17 bits (round half up)
  - s = 0: y = x
  - left: y = x << |s| computed in 24 bits, saturated to [-32768, 32767]
- Pipeline: 2 register stages.
  - Stage 1: shift/round into wide value.
  - Stage 2: saturate, set sat flag.
  - Latency is 2 cycles from input handshake to m_out valid with no stall; throughput is 1 beat/cycle.
  - tkeep and tlast travel with their data.
  - A stage advances when it is empty or the downstream stage advances.
  - s_in_payload_tready = !stage1_valid OR stage1 advances. There is no combinational path from m_out_payload_tready other than through this advance logic.
  - Data is held stable while valid && !ready.
- Sat counter timing: increments on the stage-2 load of a saturated beat. If a clearing write coincides with an increment, the clear wins and the result is 0.
- Context: pure passthrough (m_out_context_* = s_in_context_*, s_in_context_tready = m_out_context_tready). There is no ordering coupling to payload.

Decomposition:
- shiftright_pkg: register offsets (REG_SHIFT, REG_SAT_COUNT, REG_COMPAT), field positions/widths (SHIFT_W=5, ROUND_BIT=8), COMPAT value, shift clamp limits.
- Sub-module shiftright_lane: one 16-bit lane with the 2-stage shift/round/saturate datapath and a stage-enable input. It is instantiated twice (I, Q) and outputs sat flag per lane.

Test Plan:
1. Reset, then read 0x00/0x04/0x08 -> 0x0, 0x0, 0x0001_0000, each ack one cycle after rd; read 0x10 -> 0 with ack.
2. SHIFT=2, ROUND_EN=0; send I=5,Q=-5 -> I=1,Q=-2. Set ROUND_EN=1 -> I=(5+2)>>2=1, Q=-1; output valid 2 cycles after input handshake.
3. SHIFT=-2 (0x1E); send I=10000,Q=-9000 -> I=32767,Q=-32768, SAT_COUNT=1. Send I=100,Q=100 -> 400/400, count stays 1. Write 0x04 -> reads 0.
4. 8-beat packet at SHIFT=1; write SHIFT=3 after beat 3 -> all 8 beats use shift 1; next packet uses shift 3.
5. Random m_out_payload_tready (50%) over 1000 beats -> no loss/duplication, tlast/tkeep aligned, output matches model, data stable while stalled.
6. Assert ce_rst for 1 cycle mid-packet with 2 beats in pipeline -> no outputs, m_out_payload_tvalid=0 next cycle, registers default, next beat treated as sop.
